// File: rtl/cordic_sched_pkg.sv
// Shared types and defaults for the cordic scheduler.
// Build option: CORDIC_SCHED_TIMEOUT_EN enables the core watchdog.
package cordic_sched_pkg;

  localparam int DATA_W_DEF  = 23;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the
// first asserted request at or after ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    idx   = '0;
    // farthest first, so the request nearest ptr wins
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = PW'((int'(ptr) + off) % NUM_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one cordic core among requesters.
// Build option: CORDIC_SCHED_TIMEOUT_EN adds a busy watchdog.
module cordic_sched
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_theta,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      resp_error,
  output logic                      cordic_clk_en,
  output logic                      cordic_start,
  output logic [DATA_W-1:0]         cordic_theta,
  input  logic                      cordic_done,
  input  logic [DATA_W-1:0]         cordic_result
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  state_t              state, state_d;
  logic [PW-1:0]       rr_ptr, rr_ptr_d;
  logic [PW-1:0]       owner, owner_d;
  logic [PW-1:0]       gidx;
  logic [NUM_REQ-1:0]  grant;
  logic [DATA_W-1:0]   theta_sel, theta_d, result_d;
  logic                expired;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PW     (PW)
  ) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(grant)
  );

  always_comb begin
    gidx      = '0;
    theta_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx      = PW'(i);
        theta_sel = req_theta[i*DATA_W +: DATA_W];
      end
    end
  end

  // reset gate keeps req_ready low while reset is asserted
  assign req_ready = (state == IDLE && clk_en && reset) ? grant : '0;
  assign cordic_start  = clk_en && (state == ISSUE);
  assign cordic_clk_en = clk_en && (state == ISSUE || state == BUSY);
  assign resp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;

  always_comb begin
    state_d  = state;
    rr_ptr_d = rr_ptr;
    owner_d  = owner;
    theta_d  = cordic_theta;
    result_d = resp_result;
    if (clk_en) begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            theta_d  = theta_sel;
            owner_d  = gidx;
            rr_ptr_d = (gidx == LAST) ? '0 : gidx + 1'b1;
            state_d  = ISSUE;
          end
        end
        ISSUE: state_d = BUSY;
        BUSY: begin
          if (cordic_done) begin
            result_d = cordic_result;
            state_d  = RESP;
          end else if (expired) begin
            result_d = '0;
            state_d  = RESP;
          end
        end
        RESP: begin
          if (resp_ready[owner]) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      cordic_theta <= '0;
      resp_result  <= '0;
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_ptr_d;
      owner        <= owner_d;
      cordic_theta <= theta_d;
      resp_result  <= result_d;
    end
  end

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt, cnt_d;
  logic          err_q, err_d;

  assign expired    = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign resp_error = err_q;

  // cleared in ISSUE so it starts at zero on BUSY entry
  always_comb begin
    cnt_d = cnt;
    err_d = err_q;
    if (clk_en) begin
      if (state == ISSUE) begin
        cnt_d = '0;
      end else if (state == BUSY) begin
        cnt_d = cnt + 1'b1;
        if (cordic_done)  err_d = 1'b0;
        else if (expired) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign expired    = 1'b0;
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched: vector table, corner
// sequences and a randomized run against a transaction model.
module tb_cordic_sched;

  localparam int N  = 3;
  localparam int W  = 23;
  localparam int TO = 8;
  localparam logic [W-1:0] KEY = 23'h15A5A5;
  localparam logic [N*W-1:0] THETAS =
    {23'h7FFFFF, 23'h0ABCDE, 23'h200000};

  logic           clk = 1'b0;
  logic           reset;
  logic           clk_en;
  logic [N-1:0]   req_valid, req_ready;
  logic [N-1:0]   resp_valid, resp_ready;
  logic [N*W-1:0] req_theta;
  logic [W-1:0]   resp_result, cordic_theta, cordic_result;
  logic           resp_error, cordic_clk_en, cordic_start;
  logic           cordic_done;

  cordic_sched #(
    .NUM_REQ       (N),
    .DATA_W        (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .req_valid    (req_valid),
    .req_theta    (req_theta),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_error   (resp_error),
    .cordic_clk_en(cordic_clk_en),
    .cordic_start (cordic_start),
    .cordic_theta (cordic_theta),
    .cordic_done  (cordic_done),
    .cordic_result(cordic_result)
  );

  always #5 clk = ~clk;

  // core model: done appears lat enabled cycles after start
  int         core_lat  = 1;
  int         core_left = -1;
  logic       mute = 1'b0, late = 1'b0, use_ovr = 1'b0;
  logic [W-1:0] ovr_val = '0, core_val = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_left <= -1;
    end else if (cordic_clk_en) begin
      if (cordic_start) begin
        core_left <= core_lat - 1;
        core_val  <= use_ovr ? ovr_val : (cordic_theta ^ KEY);
      end else if (core_left >= 0) begin
        core_left <= core_left - 1;
      end
    end
  end

  assign cordic_done   = ((core_left == 0) && !mute) || late;
  assign cordic_result = cordic_done ? core_val : 23'h3C3C3C;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // from IDLE: request, accept, then stop at the start cycle
  task automatic issue(input logic [N-1:0] v, input logic [N-1:0] g,
                       input logic [W-1:0] th, input int lat,
                       input logic [W-1:0] res, input string nm);
    core_lat   = lat;
    ovr_val    = res;
    use_ovr    = 1'b1;
    req_theta  = THETAS;
    resp_ready = '0;
    req_valid  = v;
    #1;
    chk({nm, "_grant"}, 32'(req_ready), 32'(g));
    cyc();
    req_valid = '0;
    req_theta = '1;
    chk({nm, "_start"}, 32'(cordic_start), 32'd1);
    chk({nm, "_theta"}, 32'(cordic_theta), 32'(th));
  endtask

  task automatic wait_resp(input string nm, output int k);
    int extra;
    k     = 0;
    extra = 0;
    while (resp_valid == '0 && k < 200) begin
      cyc();
      k++;
      if (cordic_start) extra++;
    end
    chk({nm, "_one_start"}, 32'(extra), 32'd0);
  endtask

  task automatic ack(input logic [N-1:0] g, input string nm);
    resp_ready = g;
    cyc();
    resp_ready = '0;
    chk({nm, "_ack"}, 32'(resp_valid), 32'd0);
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v,
                                           input int p);
    for (int o = 0; o < N; o++)
      if (v[(p + o) % N]) return N'(1) << ((p + o) % N);
    return '0;
  endfunction

  typedef struct {
    logic [N-1:0] v;
    int           lat;
    logic [W-1:0] res;
    logic [N-1:0] g;
    logic [W-1:0] th;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int flag;
    int m_ptr, m_owner, m_wait, jobs;
    logic m_busy;
    logic [W-1:0] m_theta;
    logic [N-1:0] exp_g;

    tbl[0] = '{3'b001, 10, 23'h01234A, 3'b001, 23'h200000};
    tbl[1] = '{3'b011,  3, 23'h000001, 3'b010, 23'h0ABCDE};
    tbl[2] = '{3'b011,  1, 23'h7FFFFF, 3'b001, 23'h200000};
    tbl[3] = '{3'b011,  2, 23'h000000, 3'b010, 23'h0ABCDE};
    tbl[4] = '{3'b111,  1, 23'h2AAAAA, 3'b100, 23'h7FFFFF};
    tbl[5] = '{3'b111,  4, 23'h155555, 3'b001, 23'h200000};
    tbl[6] = '{3'b101,  2, 23'h333333, 3'b100, 23'h7FFFFF};
    tbl[7] = '{3'b110,  5, 23'h444444, 3'b010, 23'h0ABCDE};
    tbl[8] = '{3'b001,  1, 23'h0F0F0F, 3'b001, 23'h200000};

    reset      = 1'b1;
    clk_en     = 1'b1;
    req_valid  = 3'b111;
    resp_ready = '0;
    req_theta  = THETAS;
    #1 reset = 1'b0;
    cyc();
    cyc();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_ctrl", {29'd0, cordic_start, cordic_clk_en, resp_error},
        32'd0);
    chk("rst_data", 32'(resp_result | cordic_theta), 32'd0);
    req_valid = '0;
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].v, tbl[i].g, tbl[i].th, tbl[i].lat, tbl[i].res,
            $sformatf("vec%0d", i));
      wait_resp($sformatf("vec%0d", i), k);
      chk($sformatf("vec%0d_latency", i), 32'(k), 32'(tbl[i].lat + 1));
      chk($sformatf("vec%0d_valid", i), 32'(resp_valid), 32'(tbl[i].g));
      chk($sformatf("vec%0d_result", i), 32'(resp_result),
          32'(tbl[i].res));
      chk($sformatf("vec%0d_error", i), 32'(resp_error), 32'd0);
      ack(tbl[i].g, $sformatf("vec%0d", i));
    end

    // backpressure, with other requesters and stray resp_ready
    issue(3'b111, 3'b010, 23'h0ABCDE, 2, 23'h565656, "bp");
    wait_resp("bp", k);
    chk("bp_latency", 32'(k), 32'd3);
    req_valid  = 3'b111;
    resp_ready = 3'b101;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_valid", 32'(resp_valid), 32'b010);
      chk("bp_hold_result", 32'(resp_result), 32'h565656);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    resp_ready = 3'b010;
    cyc();
    resp_ready = '0;
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'b100);
    req_valid = '0;
    cyc();

    // clock-enable stall in BUSY, then in RESP
    issue(3'b001, 3'b001, 23'h200000, 6, 23'h606060, "stall");
    cyc();
    cyc();
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_core_en",
          {29'd0, cordic_clk_en, cordic_start, |resp_valid}, 32'd0);
      cyc();
    end
    clk_en = 1'b1;
    wait_resp("stall", k);
    chk("stall_latency", 32'(k + 6), 32'd11);
    chk("stall_result", 32'(resp_result), 32'h606060);
    clk_en     = 1'b0;
    resp_ready = 3'b001;
    cyc();
    cyc();
    chk("stall_resp_hold", 32'(resp_valid), 32'b001);
    clk_en = 1'b1;
    cyc();
    resp_ready = '0;
    chk("stall_resp_done", 32'(resp_valid), 32'd0);

    // asynchronous reset in the middle of a job
    issue(3'b010, 3'b010, 23'h0ABCDE, 20, 23'h777777, "mrst");
    cyc();
    cyc();
    cyc();
    req_valid = 3'b111;
    #2 reset = 1'b0;
    #1;
    chk("mrst_ready", 32'(req_ready), 32'd0);
    chk("mrst_ctrl",
        {28'd0, cordic_start, cordic_clk_en, resp_error, |resp_valid},
        32'd0);
    chk("mrst_data", 32'(resp_result | cordic_theta), 32'd0);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("mrst_ptr_zero", 32'(req_ready), 32'b001);
    req_valid = '0;
    flag = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (resp_valid != '0 || cordic_start) flag++;
    end
    chk("mrst_no_stale", 32'(flag), 32'd0);
    m_ptr = 0;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    mute = 1'b1;
    issue(3'b001, 3'b001, 23'h200000, 3, 23'h111111, "tmo");
    wait_resp("tmo", k);
    chk("tmo_latency", 32'(k), 32'd9);
    chk("tmo_valid", 32'(resp_valid), 32'b001);
    chk("tmo_error", 32'(resp_error), 32'd1);
    chk("tmo_result", 32'(resp_result), 32'd0);
    late = 1'b1;
    cyc();
    late = 1'b0;
    chk("tmo_late_err", 32'(resp_error), 32'd1);
    chk("tmo_late_res", 32'(resp_result), 32'd0);
    ack(3'b001, "tmo");
    mute  = 1'b0;
    m_ptr = 1;
`endif

    // randomized run against a transaction-level model
    use_ovr = 1'b0;
    m_busy  = 1'b0;
    m_owner = 0;
    m_theta = '0;
    m_wait  = 0;
    jobs    = 0;
    for (int c = 0; c < 600; c++) begin
      cyc();
      clk_en     = ($urandom_range(0, 9) != 0);
      req_valid  = N'($urandom);
      resp_ready = N'($urandom);
      core_lat   = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) req_theta[i*W +: W] = W'($urandom);
      #1;
      exp_g = (!m_busy && clk_en) ? rr_pick(req_valid, m_ptr) : '0;
      chk("rnd_ready", 32'(req_ready), 32'(exp_g));
      if (cordic_start) begin
        chk("rnd_start_busy", 32'(m_busy), 32'd1);
        chk("rnd_theta", 32'(cordic_theta), 32'(m_theta));
      end
      if (resp_valid != '0) begin
        chk("rnd_resp_owner", {31'd0, m_busy, 32'(resp_valid)} >> 0,
            {31'd0, 1'b1, 32'(N'(1) << m_owner)});
        chk("rnd_resp_result", 32'(resp_result), 32'(m_theta ^ KEY));
        chk("rnd_resp_error", 32'(resp_error), 32'd0);
      end
      if (m_busy) m_wait++;
      if (clk_en) begin
        if (!m_busy && exp_g != '0) begin
          for (int i = 0; i < N; i++)
            if (exp_g[i]) begin
              m_owner = i;
              m_theta = req_theta[i*W +: W];
              m_ptr   = (i + 1) % N;
            end
          m_busy = 1'b1;
          m_wait = 0;
        end else if (m_busy && resp_valid[m_owner] &&
                     resp_ready[m_owner]) begin
          m_busy = 1'b0;
          jobs++;
        end
      end
      if (m_wait > 300) break;
    end
    chk("rnd_not_stuck", 32'(m_wait > 300), 32'd0);
    chk("rnd_progress", 32'(jobs >= 10), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Schedules one shared cordic core between NUM_REQ requesters.
- Each requester submits a fixed-point theta over a valid/ready request channel and gets the result back on its own valid/ready response channel.
- Round-robin arbitration; the block generates the core's start/clk_en and captures its result on done.
- Sits between the front-end requesters and the single cordic instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 23, fixed-point theta/result width.
- TIMEOUT_CYCLES, 64, watchdog limit on core latency (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clk_en  in  1  global enable; low freezes all state
- req_valid  in  NUM_REQ  per-requester request valid
- req_theta  in  NUM_REQ*DATA_W  flattened thetas, requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester request accept
- resp_valid  out  NUM_REQ  one-hot response valid
- resp_ready  in  NUM_REQ  per-requester response accept
- resp_result  out  DATA_W  shared result bus
- resp_error  out  1  response is a timeout (0 when the feature is compiled out)
- cordic_clk_en  out  1  core clock enable
- cordic_start  out  1  one-cycle core start pulse
- cordic_theta  out  DATA_W  core input, registered
- cordic_done  in  1  core completion
- cordic_result  in  DATA_W  core result, valid with done

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0.
  - All outputs 0: resp_result, cordic_theta, resp_error, cordic_start, cordic_clk_en, req_ready, resp_valid.
  - Reset mid-operation abandons the in-flight job; no response is produced.
- clk_en=0:
  - State, registers and counters hold.
  - cordic_clk_en=0, cordic_start=0, req_ready=0.
  - resp_valid holds its value, but no handshake completes.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - grant = first asserted req_valid searching from rr_ptr upward, with wrap.
  - req_ready = grant (combinational; at most one bit high).
  - On valid&ready: latch theta into cordic_theta, owner=grant, rr_ptr=(grant+1) mod NUM_REQ, go to ISSUE.
  - No request: stay in IDLE, rr_ptr unchanged.
- ISSUE: cordic_start=1 for exactly one cycle, go to BUSY.
- BUSY:
  - Wait for cordic_done=1, then capture resp_result=cordic_result, resp_error=0, go to RESP.
  - cordic_done outside BUSY (including in ISSUE) is ignored.
- RESP:
  - resp_valid[owner]=1; resp_result and resp_error are stable until the handshake.
  - When resp_ready[owner]=1, go to IDLE; resp_ready of other bits is ignored.
- cordic_clk_en = clk_en and state is ISSUE or BUSY.
- Latency:
  - Request accepted at cycle T, start at T+1.
  - Done seen at cycle D gives resp_valid at D+1.
  - Minimum request-to-response is 3 cycles plus core latency.
- Throughput: one job in flight; req_ready=0 outside IDLE.
- Fairness: a requester that keeps req_valid high is served within NUM_REQ grants.
- Requesters may change or drop req_theta/req_valid before the handshake; only the accepted theta is used.

Optional Feature:
- Macro CORDIC_SCHED_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to BUSY and increments each enabled cycle in BUSY.
  - When it reaches TIMEOUT_CYCLES without done: go to RESP with resp_result=0 and resp_error=1.
  - A late cordic_done after the timeout is ignored.
- Disabled: no counter; BUSY waits indefinitely; resp_error is tied to 0.

Decomposition:
- Package cordic_sched_pkg:
  - DATA_W default constant.
  - State enum (IDLE/ISSUE/BUSY/RESP, 2-bit).
  - Default TIMEOUT_CYCLES.
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs req and ptr; output one-hot grant.
  - Purely combinational.
- All registers live in cordic_sched.

Test Plan:
- Single request: req_valid=01, theta=23'h200000, core returns 23'h1234A after 10 cycles -> one cordic_start pulse with cordic_theta=23'h200000; resp_valid=01 with resp_result=23'h1234A 11 cycles after start.
- Contention: req_valid=11 held high, rr_ptr=0 -> grants in order 0,1,0,1; each response goes to the matching resp_valid bit.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_result stable, req_ready=0 throughout; the next grant occurs only after resp_ready=1.
- Stall: clk_en=0 for 4 cycles during BUSY -> cordic_clk_en=0, state held; the job completes normally after clk_en returns to 1.
- Reset mid-job: reset=0 asynchronously in BUSY -> all outputs 0 immediately; after release, IDLE with rr_ptr=0 and no stale response.
- With CORDIC_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8, core never asserts done -> resp_valid 9 cycles after start with resp_error=1 and resp_result=0; a late cordic_done is ignored.
